// File: rtl/link_monitor.sv
// Link health monitor for a decoded 8b10b symbol stream.
// It tracks the lock state, the windowed error rate, symbol timeouts and the error totals.
module link_monitor #(
  parameter int CLK_RATE_HZ = 60_000_000,
  parameter int TIMEOUT_US  = 100,
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW_SYMS = 1024,
  parameter int ERR_THRESH  = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [2:0]  i_error,
  input  logic        i_clear,
  output logic [1:0]  o_state,
  output logic        o_link_up,
  output logic [15:0] o_err_count,
  output logic [2:0]  o_err_sticky,
  output logic        o_event_valid,
  output logic [7:0]  o_event
);
  localparam int TIMEOUT_CLKS = (CLK_RATE_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int CW = $clog2(LOCK_COUNT + 2);
  localparam int SW = $clog2(WINDOW_SYMS + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_COUNT);
  localparam logic [SW-1:0] WIN_C    = SW'(WINDOW_SYMS);
  localparam logic [EW-1:0] ERR_C    = EW'(ERR_THRESH);

  typedef enum logic [1:0] {DOWN = 2'd0, ACQUIRE = 2'd1, UP = 2'd2, DEGRADED = 2'd3} state_t;

  state_t        st, st_nx;
  logic [TW-1:0] tmr;
  logic [CW-1:0] clean_cnt, clean_inc, clean_nx;
  logic [SW-1:0] win_syms, syms_inc, syms_nx;
  logic [EW-1:0] win_errs, errs_inc, errs_nx;
  logic [2:0]    sticky_nx;
  logic          err, expire, tflag;

  assign o_state = st;

  always_comb begin
    err       = i_valid && (i_error != 3'b000);
    expire    = (st != DOWN) && !i_valid && (tmr == TMO_LAST);
    sticky_nx = i_clear ? (i_valid ? i_error : 3'b000)
                        : (i_valid ? (o_err_sticky | i_error) : o_err_sticky);
    clean_inc = clean_cnt + 1'b1;
    syms_inc  = win_syms + 1'b1;
    errs_inc  = (err && win_errs != ERR_C) ? win_errs + 1'b1 : win_errs;
    st_nx     = st;
    clean_nx  = clean_cnt;
    syms_nx   = win_syms;
    errs_nx   = win_errs;
    tflag     = 1'b0;
    if (expire) begin
      st_nx    = DOWN;
      clean_nx = '0;
      syms_nx  = '0;
      errs_nx  = '0;
      tflag    = 1'b1;
    end else if (i_valid) begin
      case (st)
        DOWN: if (!err) begin
          st_nx    = ACQUIRE;
          clean_nx = CW'(1);
        end
        ACQUIRE: if (err) begin
          st_nx    = DOWN;
          clean_nx = '0;
        end else if (clean_inc >= LOCK_C) begin
          st_nx    = UP;
          clean_nx = '0;
          syms_nx  = '0;
          errs_nx  = '0;
        end else begin
          clean_nx = clean_inc;
        end
        default: begin
          // Hitting the error threshold wins over a window that completes on the same symbol
          if (err && errs_inc >= ERR_C) begin
            st_nx   = DOWN;
            syms_nx = '0;
            errs_nx = '0;
          end else if (syms_inc >= WIN_C) begin
            syms_nx = '0;
            errs_nx = '0;
            st_nx   = (st == UP && err) ? DEGRADED : UP;
          end else begin
            syms_nx = syms_inc;
            errs_nx = errs_inc;
            if (err) st_nx = DEGRADED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      st            <= DOWN;
      tmr           <= '0;
      clean_cnt     <= '0;
      win_syms      <= '0;
      win_errs      <= '0;
      o_link_up     <= 1'b0;
      o_err_count   <= '0;
      o_err_sticky  <= '0;
      o_event_valid <= 1'b0;
      o_event       <= '0;
    end else begin
      st           <= st_nx;
      clean_cnt    <= clean_nx;
      win_syms     <= syms_nx;
      win_errs     <= errs_nx;
      o_link_up    <= st_nx[1];
      o_err_sticky <= sticky_nx;
      // The timer only runs while there is a link to lose
      if (i_valid || st == DOWN || expire) tmr <= '0;
      else                                  tmr <= tmr + 1'b1;
      if (i_clear)                            o_err_count <= {15'd0, err};
      else if (err && o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
      o_event_valid <= (st_nx != st);
      if (st_nx != st) o_event <= {st, st_nx, sticky_nx, tflag};
    end
  end
endmodule

// File: tb/tb_link_monitor.sv
// Scoreboard bench for link_monitor: the stimulus queues the expected events and a monitor compares them.
module tb_link_monitor;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid = 1'b0, clear = 1'b0;
  logic [2:0]  error = 3'b000;
  logic [1:0]  state;
  logic        link_up, ev_valid;
  logic [15:0] err_count;
  logic [2:0]  sticky;
  logic [7:0]  ev;
  logic        v1 = 1'b0;
  logic [1:0]  state1;
  logic        link_up1, ev_valid1;
  logic [15:0] err_count1;
  logic [2:0]  sticky1;
  logic [7:0]  ev1;

  link_monitor dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_error(error), .i_clear(clear),
    .o_state(state), .o_link_up(link_up), .o_err_count(err_count), .o_err_sticky(sticky),
    .o_event_valid(ev_valid), .o_event(ev));

  link_monitor #(.LOCK_COUNT(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .i_error(3'b000), .i_clear(1'b0),
    .o_state(state1), .o_link_up(link_up1), .o_err_count(err_count1), .o_err_sticky(sticky1),
    .o_event_valid(ev_valid1), .o_event(ev1));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] ev; logic [1:0] st; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [7:0] e, input logic [1:0] s);
    exp_t x;
    x.ev = e;
    x.st = s;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (ev_valid) begin
      exp_t x;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %h expected none at %0t", ev, $time);
      end else begin
        x = q.pop_front();
        chk("event", {24'd0, ev}, {24'd0, x.ev});
        chk("event_state", {30'd0, state}, {30'd0, x.st});
      end
    end
  end

  // Issue one symbol after gap idle cycles; returns just after the capturing edge.
  task automatic sym(input logic [2:0] e, input int gap);
    repeat (gap) @(posedge clk);
    #1 valid = 1'b1; error = e;
    @(posedge clk);
    #1 valid = 1'b0; error = 3'b000;
  endtask

  task automatic burst(input int n, input logic [2:0] e);
    valid = 1'b1; error = e;
    repeat (n) @(posedge clk);
    #1 valid = 1'b0; error = 3'b000;
  endtask

  task automatic lock(input logic [2:0] s, input int n);
    for (int i = 1; i <= n; i++) begin
      if (i == 1)  push_ev({2'd0, 2'd1, s, 1'b0}, 2'd1);
      if (i == 64) push_ev({2'd1, 2'd2, s, 1'b0}, 2'd2);
      sym(3'b000, 9);
      if (i == 1) chk("acquire_after_first", {30'd0, state}, 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_link_up", {31'd0, link_up}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_sticky", {29'd0, sticky}, 32'd0);
    chk("rst_event", {24'd0, ev}, 32'd0);
    chk("rst_event_valid", {31'd0, ev_valid}, 32'd0);
    #1 rst = 1'b0;

    // LOCK_COUNT=1: one clean symbol to ACQUIRE, the next to UP
    @(posedge clk); #1 v1 = 1'b1; @(posedge clk); #1 v1 = 1'b0;
    chk("lc1_acquire", {30'd0, state1}, 32'd1);
    @(posedge clk); #1 v1 = 1'b1; @(posedge clk); #1 v1 = 1'b0;
    chk("lc1_up", {30'd0, state1}, 32'd2);
    chk("lc1_link_up", {31'd0, link_up1}, 32'd1);

    lock(3'b000, 64);
    chk("lock_up", {30'd0, state}, 32'd2);
    chk("lock_link_up", {31'd0, link_up}, 32'd1);

    // One error degrades; a clean remainder of the window restores UP
    push_ev(8'hB2, 2'd3);
    sym(3'b001, 1);
    chk("deg_state", {30'd0, state}, 32'd3);
    chk("deg_err_count", {16'd0, err_count}, 32'd1);
    chk("deg_sticky", {29'd0, sticky}, 32'd1);
    for (int i = 1; i <= 1023; i++) begin
      if (i == 1023) begin
        chk("deg_before_window_end", {30'd0, state}, 32'd3);
        push_ev(8'hE2, 2'd2);
      end
      sym(3'b000, 1);
    end
    chk("window_restores_up", {30'd0, state}, 32'd2);

    // Eight errors within one window drop the link
    push_ev(8'hB6, 2'd3);
    push_ev(8'hC6, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("seven_errs_degraded", {30'd0, state}, 32'd3);
      sym(3'b010, 1);
    end
    chk("thresh_down", {30'd0, state}, 32'd0);
    chk("thresh_link_up", {31'd0, link_up}, 32'd0);
    chk("thresh_err_count", {16'd0, err_count}, 32'd9);

    @(posedge clk); #1 clear = 1'b1; @(posedge clk); #1 clear = 1'b0;
    chk("clear_err_count", {16'd0, err_count}, 32'd0);
    chk("clear_sticky", {29'd0, sticky}, 32'd0);

    // Timeout after 6000 idle cycles
    lock(3'b000, 64);
    repeat (5999) @(posedge clk);
    #1 chk("before_timeout", {30'd0, state}, 32'd2);
    push_ev(8'h81, 2'd0);
    @(posedge clk); #1;
    chk("timeout_down", {30'd0, state}, 32'd0);
    chk("timeout_link_up", {31'd0, link_up}, 32'd0);

    // A symbol on the expiry cycle keeps the link up
    lock(3'b000, 64);
    repeat (5999) @(posedge clk);
    #1 valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("expiry_valid_up", {30'd0, state}, 32'd2);

    // Saturating error count, then clear coincident with an error
    push_ev(8'hB8, 2'd3);
    push_ev(8'hC8, 2'd0);
    burst(70000, 3'b100);
    chk("sat_err_count", {16'd0, err_count}, 32'h0000FFFF);
    #1 clear = 1'b1; valid = 1'b1; error = 3'b010;
    @(posedge clk); #1 clear = 1'b0; valid = 1'b0; error = 3'b000;
    chk("clear_err_coinc_count", {16'd0, err_count}, 32'd1);
    chk("clear_err_coinc_sticky", {29'd0, sticky}, 32'd2);

    // Reset mid-acquisition, then a fresh lock
    lock(3'b010, 40);
    #2 rst = 1'b1;
    #1 chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_err_count", {16'd0, err_count}, 32'd0);
    chk("midrst_sticky", {29'd0, sticky}, 32'd0);
    chk("midrst_event_valid", {31'd0, ev_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    lock(3'b000, 64);
    chk("relock_up", {30'd0, state}, 32'd2);
    repeat (5) @(posedge clk);
    chk("events_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
